// File: rtl/imem_loader_if.sv
// Stream-in / byte-write-out bundle for the boot-time instruction memory loader.
interface imem_loader_if #(
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic          start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          overflow;
  logic [31:0]   checksum;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  core_hold, load_done, overflow, checksum
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output core_hold, load_done, overflow, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// Splits 32-bit boot words into little-endian byte writes and holds the core until loaded.
// Optional running word sum on bus.checksum when IMEM_LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; core held, waiting for start
// S_LOAD  | in_ready high, waiting for the next word
// S_WRITE | emitting the four bytes of the latched word, one per cycle
// S_DONE  | image complete (or overflowed); core released
module imem_loader #(
  parameter int ADD_WIDTH = 8,
  parameter int DEPTH     = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  imem_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [AW-1:0]         r_addr;
  logic [AW-1:0]         w_addr_nx;
  logic [1:0]            r_idx;
  logic [1:0]            w_idx_nx;
  logic [31:0]           r_word;
  logic [31:0]           w_word_nx;
  logic                  r_last;
  logic                  w_last_nx;
  logic                  r_ovf;
  logic                  w_ovf_nx;
  logic [ADD_WIDTH-1:0]  w_byte_nx;

  logic                  r_in_ready;
  logic                  r_mem_we;
  logic [ADD_WIDTH-1:0]  r_mem_wdata;
  logic                  r_core_hold;
  logic                  r_load_done;

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_idx_nx   = r_idx;
    w_word_nx  = r_word;
    w_last_nx  = r_last;
    w_ovf_nx   = r_ovf;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nx = S_LOAD;
          w_addr_nx  = '0;
          w_ovf_nx   = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.in_valid && r_in_ready) begin
          w_word_nx  = bus.in_data;
          w_last_nx  = bus.in_last;
          w_idx_nx   = 2'd0;
          w_state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        w_addr_nx = r_addr + 1'b1;
        w_idx_nx  = r_idx + 1'b1;
        if (r_idx == 2'd3) begin
          // in_last wins over a wrap: a full image ending exactly at DEPTH is not an overflow
          if (r_last) begin
            w_state_nx = S_DONE;
          end else if (r_addr == AW'(DEPTH - 1)) begin
            w_state_nx = S_DONE;
            w_ovf_nx   = 1'b1;
          end else begin
            w_state_nx = S_LOAD;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_byte_nx = w_word_nx[{w_idx_nx, 3'b000} +: ADD_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_idx   <= 2'd0;
      r_word  <= '0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_idx   <= w_idx_nx;
      r_word  <= w_word_nx;
      r_last  <= w_last_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_core_hold <= 1'b1;
      r_load_done <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nx == S_LOAD);
      r_mem_we    <= (w_state_nx == S_WRITE);
      r_mem_wdata <= w_byte_nx;
      r_core_hold <= (w_state_nx != S_DONE);
      r_load_done <= (w_state_nx == S_DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.core_hold = r_core_hold;
  assign bus.load_done = r_load_done;
  assign bus.overflow  = r_ovf;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic        w_accept;
  logic        w_clear;
  logic [31:0] r_checksum;

  assign w_accept = (r_state == S_LOAD) && bus.in_valid && r_in_ready;
  assign w_clear  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if (w_clear) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + bus.in_data;
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte order, pacing, gaps, overflow, async reset, restart.
module tb_imem_loader;
  localparam int DEPTH = 32;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] exp_sum = '0;

  imem_loader_if #(.DEPTH(DEPTH)) bus ();

  imem_loader #(.ADD_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ck_exp(input logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0 & s;
`endif
  endfunction

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    exp_sum   = '0;
    chk("start_in_ready",  32'(bus.in_ready),  32'd1);
    chk("start_core_hold", 32'(bus.core_hold), 32'd1);
    chk("start_load_done", 32'(bus.load_done), 32'd0);
    chk("start_overflow",  32'(bus.overflow),  32'd0);
    chk("start_mem_we",    32'(bus.mem_we),    32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last, input int base, input logic hold);
    logic [31:0] b;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.in_last  = last;
    for (int t = 0; t < 20 && bus.in_ready !== 1'b1; t++) tick();
    chk("wait_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    exp_sum = exp_sum + w;
    if (!hold) bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = (w >> (8 * k)) & 32'hFF;
      chk("wr_mem_we",   32'(bus.mem_we),    32'd1);
      chk("wr_mem_addr", 32'(bus.mem_addr),  32'((base + k) % DEPTH));
      chk("wr_wdata",    32'(bus.mem_wdata), b);
      chk("wr_in_ready", 32'(bus.in_ready),  32'd0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #12;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_wdata",     32'(bus.mem_wdata), 32'd0);
    chk("rst_core_hold", 32'(bus.core_hold), 32'd1);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_checksum",  bus.checksum,       32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // IDLE ignores in_valid
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hCAFEF00D;
    tick();
    tick();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    chk("idle_mem_we",   32'(bus.mem_we),   32'd0);
    bus.in_valid = 1'b0;

    // single word image
    start_pulse();
    send_word(32'h00500093, 1'b1, 0, 1'b0);
    chk("w1_load_done", 32'(bus.load_done), 32'd1);
    chk("w1_core_hold", 32'(bus.core_hold), 32'd0);
    chk("w1_in_ready",  32'(bus.in_ready),  32'd0);
    chk("w1_overflow",  32'(bus.overflow),  32'd0);
    chk("w1_checksum",  bus.checksum,       ck_exp(32'h00500093));

    // restart from DONE, three words back-to-back with in_valid held
    start_pulse();
    send_word(32'h00500093, 1'b0, 0, 1'b1);
    chk("w3a_in_ready", 32'(bus.in_ready), 32'd1);
    send_word(32'h00A00113, 1'b0, 4, 1'b1);
    chk("w3b_in_ready", 32'(bus.in_ready), 32'd1);
    send_word(32'h002081B3, 1'b1, 8, 1'b0);
    chk("w3_load_done", 32'(bus.load_done), 32'd1);
    chk("w3_core_hold", 32'(bus.core_hold), 32'd0);
    chk("w3_checksum",  bus.checksum,       ck_exp(32'h01108359));

    // gap of three cycles between words
    start_pulse();
    send_word(32'h11223344, 1'b0, 0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      chk("gap_in_ready", 32'(bus.in_ready), 32'd1);
      chk("gap_mem_we",   32'(bus.mem_we),   32'd0);
      chk("gap_addr",     32'(bus.mem_addr), 32'd4);
      tick();
    end
    send_word(32'h55667788, 1'b1, 4, 1'b0);
    chk("gap_load_done", 32'(bus.load_done), 32'd1);

    // overflow: eight words fill DEPTH, ninth never taken
    start_pulse();
    for (int i = 0; i < 8; i++) begin
      send_word(32'hA0B0C000 + 32'(i), 1'b0, 4 * i, 1'b1);
    end
    chk("ovf_overflow",  32'(bus.overflow),  32'd1);
    chk("ovf_load_done", 32'(bus.load_done), 32'd1);
    chk("ovf_in_ready",  32'(bus.in_ready),  32'd0);
    bus.in_data = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("ovf_no_we",    32'(bus.mem_we),    32'd0);
      chk("ovf_no_ready", 32'(bus.in_ready),  32'd0);
      tick();
    end
    chk("ovf_checksum", bus.checksum, ck_exp(exp_sum));
    bus.in_valid = 1'b0;

    // async reset at the second byte
    start_pulse();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.in_last  = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("rw_b0_we",   32'(bus.mem_we),    32'd1);
    chk("rw_b0_data", 32'(bus.mem_wdata), 32'hEF);
    tick();
    chk("rw_b1_we",   32'(bus.mem_we),   32'd1);
    chk("rw_b1_addr", 32'(bus.mem_addr), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rw_async_we",   32'(bus.mem_we),    32'd0);
    chk("rw_async_hold", 32'(bus.core_hold), 32'd1);
    chk("rw_async_addr", 32'(bus.mem_addr),  32'd0);
    chk("rw_async_ck",   bus.checksum,       32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("rw_post_ready", 32'(bus.in_ready),  32'd0);
    chk("rw_post_we",    32'(bus.mem_we),    32'd0);
    chk("rw_post_done",  32'(bus.load_done), 32'd0);
    start_pulse();
    send_word(32'h12345678, 1'b1, 0, 1'b0);
    chk("rw_final_done", 32'(bus.load_done), 32'd1);
    chk("rw_final_ck",   bus.checksum,       ck_exp(32'h12345678));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
